// File: rtl/input_descaler.sv
// Windowed ADC sample accumulator with offset removal, shift scaling and unsigned saturation.
// Optional saturation counter enabled by defining INPUT_SAT_COUNT_EN.
module input_descaler #(
  parameter logic [15:0] START_REG = 16'd2,
  parameter logic [15:0] LEN_REG   = 16'd3,
  parameter logic [15:0] OFFL_REG  = 16'd4,
  parameter logic [15:0] OFFH_REG  = 16'd5,
  parameter logic [15:0] SHIFT_REG = 16'd6,
  parameter int          OUT_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [255:0]        adc_word_in,
  input  logic                adc_word_valid,
  input  logic [31:0]         gpio_in,
  output logic [OUT_BITS-1:0] val_out,
  output logic                val_out_valid,
  output logic [15:0]         sat_count
);

  logic [15:0] gpio_addr;
  logic [7:0]  gpio_data;
  logic        wr_stb;
  logic        unused_gpio;

  logic        wclk_q;
  logic [3:0]  start_q;
  logic [4:0]  len_q;
  logic [15:0] offset_q;
  logic [3:0]  shift_q;

  assign gpio_addr   = gpio_in[15:0];
  assign gpio_data   = gpio_in[23:16];
  assign wr_stb      = gpio_in[24] & ~wclk_q;
  assign unused_gpio = ^gpio_in[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      wclk_q   <= 1'b0;
      start_q  <= 4'd4;
      len_q    <= 5'd8;
      offset_q <= 16'h0000;
      shift_q  <= 4'd3;
    end else begin
      wclk_q <= gpio_in[24];
      if (wr_stb) begin
        case (gpio_addr)
          START_REG: start_q          <= gpio_data[3:0];
          LEN_REG:   len_q            <= gpio_data[4:0];
          OFFL_REG:  offset_q[7:0]    <= gpio_data;
          OFFH_REG:  offset_q[15:8]   <= gpio_data;
          SHIFT_REG: shift_q          <= gpio_data[3:0];
          default: ;
        endcase
      end
    end
  end

  // Window mask: no wrap past sample 15, lengths above 16 clamp to the full word.
  logic [4:0]  len_eff;
  logic [5:0]  win_end;
  logic [15:0] keep;

  always_comb begin
    len_eff = (len_q > 5'd16) ? 5'd16 : len_q;
    win_end = {2'b00, start_q} + {1'b0, len_eff};
    keep    = '0;
    for (int i = 0; i < 16; i++) begin
      keep[i] = (6'(i) >= {2'b00, start_q}) && (6'(i) < win_end);
    end
  end

  logic [15:0] s1_smp_q [16];
  logic [15:0] s1_off_q;
  logic [3:0]  s1_shift_q;
  logic        s1_vld_q;

  logic [17:0] s2_part_q [4];
  logic [17:0] part_d    [4];
  logic [15:0] s2_off_q;
  logic [3:0]  s2_shift_q;
  logic        s2_vld_q;

  logic [19:0] total_d;
  logic [20:0] diff_d;
  logic [20:0] s3_diff_q;
  logic [3:0]  s3_shift_q;
  logic        s3_vld_q;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      part_d[j] = '0;
      for (int k = 0; k < 4; k++) begin
        part_d[j] = part_d[j] + {{2{s1_smp_q[4*j+k][15]}}, s1_smp_q[4*j+k]};
      end
    end
  end

  always_comb begin
    total_d = '0;
    for (int j = 0; j < 4; j++) begin
      total_d = total_d + {{2{s2_part_q[j][17]}}, s2_part_q[j]};
    end
    diff_d = {total_d[19], total_d} - {{5{s2_off_q[15]}}, s2_off_q};
  end

  logic signed [20:0]   shifted;
  logic                 lo_clip;
  logic                 hi_clip;
  logic [OUT_BITS-1:0]  val_d;

  assign shifted = $signed(s3_diff_q) >>> s3_shift_q;
  assign lo_clip = shifted[20];
  assign hi_clip = ~shifted[20] & (|shifted[19:OUT_BITS]);

  always_comb begin
    val_d = shifted[OUT_BITS-1:0];
    if (lo_clip) begin
      val_d = '0;
    end else if (hi_clip) begin
      val_d = '1;
    end
  end

  // Datapath registers carry no reset; only the valids qualify them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      s1_smp_q[i] <= keep[i] ? adc_word_in[16*i +: 16] : 16'h0000;
    end
    s1_off_q   <= offset_q;
    s1_shift_q <= shift_q;
    for (int j = 0; j < 4; j++) begin
      s2_part_q[j] <= part_d[j];
    end
    s2_off_q   <= s1_off_q;
    s2_shift_q <= s1_shift_q;
    s3_diff_q  <= diff_d;
    s3_shift_q <= s2_shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q      <= 1'b0;
      s2_vld_q      <= 1'b0;
      s3_vld_q      <= 1'b0;
      val_out_valid <= 1'b0;
      val_out       <= '0;
    end else begin
      s1_vld_q      <= adc_word_valid;
      s2_vld_q      <= s1_vld_q;
      s3_vld_q      <= s2_vld_q;
      val_out_valid <= s3_vld_q;
      if (s3_vld_q) begin
        val_out <= val_d;
      end
    end
  end

`ifdef INPUT_SAT_COUNT_EN
  logic [15:0] sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else if (wr_stb && (gpio_addr == LEN_REG)) begin
      sat_q <= '0;
    end else if (s3_vld_q && (lo_clip || hi_clip) && (sat_q != 16'hFFFF)) begin
      sat_q <= sat_q + 16'd1;
    end
  end

  assign sat_count = sat_q;
`else
  assign sat_count = '0;
`endif

endmodule
